// File: rtl/tile_fetch_sched.sv
// Tile ROM fetch scheduler: walks the enabled layers of one scan line,
// one word per REQ/GAP pair, into the line-buffer bank picked by BUF_SEL.
//
// Ports:
//   CLK_16M   in   clock, all state on rising edge
//   RESET_N   in   asynchronous active-low reset
//   LI        in   line-start pulse (one cycle)
//   LAYER_EN  in   [4:0] layer enables, latched on LI
//                  bit0 sprites, bit1..3 scroll1..3, bit4 stars
//   ROM_REQ   out  fetch request, high exactly in REQ
//   ROM_ACK   in   ROM data valid for the current request
//   ROMA      out  [2:0] layer code (ROM address bits 22:20)
//   WORD_IDX  out  [5:0] line-buffer word index
//   BUF_WE    out  line-buffer write strobe
//   BUF_SEL   out  line-buffer bank being written
//   BUSY      out  line fetch in progress
//   OVERRUN   out  sticky: LI arrived before the line was done
//   CLR_OVR   in   clears OVERRUN (a same-cycle set wins)
module tile_fetch_sched #(
    parameter int SPR_WORDS  = 32,
    parameter int SCR_WORDS  = 64,
    parameter int STAR_WORDS = 32
) (
    input  logic       CLK_16M,
    input  logic       RESET_N,
    input  logic       LI,
    input  logic [4:0] LAYER_EN,
    output logic       ROM_REQ,
    input  logic       ROM_ACK,
    output logic [2:0] ROMA,
    output logic [5:0] WORD_IDX,
    output logic       BUF_WE,
    output logic       BUF_SEL,
    output logic       BUSY,
    output logic       OVERRUN,
    input  logic       CLR_OVR
);

    // WORD_IDX is 6 bits wide, so no layer may exceed 64 words.
    if (SCR_WORDS > 64 || SCR_WORDS < 1) begin : g_scr_cfg_err
        $error("tile_fetch_sched: SCR_WORDS must be 1..64");
    end
    if (SPR_WORDS > 64 || SPR_WORDS < 1) begin : g_spr_cfg_err
        $error("tile_fetch_sched: SPR_WORDS must be 1..64");
    end
    if (STAR_WORDS > 64 || STAR_WORDS < 1) begin : g_star_cfg_err
        $error("tile_fetch_sched: STAR_WORDS must be 1..64");
    end

    localparam logic [5:0] SPR_LAST  = 6'(SPR_WORDS - 1);
    localparam logic [5:0] SCR_LAST  = 6'(SCR_WORDS - 1);
    localparam logic [5:0] STAR_LAST = 6'(STAR_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t     state_q;
    state_t     state_n;
    logic [2:0] roma_q;
    logic [2:0] roma_n;
    logic [5:0] idx_q;
    logic [5:0] idx_n;
    logic       sel_q;
    logic       sel_n;
    logic       ovr_q;
    logic       ovr_n;
    logic [4:0] en_q;
    logic [4:0] en_n;

    logic [5:0] last_idx;
    logic       li_any;
    logic [2:0] li_first;
    logic       nxt_found;
    logic [2:0] nxt_layer;

    // Last word index of the layer currently being fetched.
    always_comb begin
        last_idx = SCR_LAST;
        case (roma_q)
            3'd0:    last_idx = SPR_LAST;
            3'd4:    last_idx = STAR_LAST;
            default: last_idx = SCR_LAST;
        endcase
    end

    // Lowest enabled layer of the incoming LAYER_EN (used on LI).
    always_comb begin
        li_any   = 1'b0;
        li_first = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (LAYER_EN[i]) begin
                li_any   = 1'b1;
                li_first = 3'(i);
            end
        end
    end

    // Next higher enabled layer above the current one; the descending
    // scan leaves the lowest qualifying layer, so gaps cost no cycles.
    always_comb begin
        nxt_found = 1'b0;
        nxt_layer = roma_q;
        for (int i = 4; i >= 0; i--) begin
            if (en_q[i] && (i > int'(roma_q))) begin
                nxt_found = 1'b1;
                nxt_layer = 3'(i);
            end
        end
    end

    always_ff @(posedge CLK_16M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            roma_q  <= 3'd0;
            idx_q   <= 6'd0;
            sel_q   <= 1'b0;
            ovr_q   <= 1'b0;
            en_q    <= 5'd0;
        end else begin
            state_q <= state_n;
            roma_q  <= roma_n;
            idx_q   <= idx_n;
            sel_q   <= sel_n;
            ovr_q   <= ovr_n;
            en_q    <= en_n;
        end
    end

    always_comb begin
        state_n = state_q;
        roma_n  = roma_q;
        idx_n   = idx_q;
        sel_n   = sel_q;
        ovr_n   = ovr_q;
        en_n    = en_q;

        if (CLR_OVR) begin
            ovr_n = 1'b0;
        end

        if (LI) begin
            // LI overrides everything: restart the line in the other bank.
            sel_n = ~sel_q;
            en_n  = LAYER_EN;
            idx_n = 6'd0;
            if (li_any) begin
                roma_n  = li_first;
                state_n = S_REQ;
            end else begin
                state_n = S_IDLE;
            end
            if (state_q != S_IDLE) begin
                ovr_n = 1'b1;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (ROM_ACK) begin
                        state_n = S_GAP;
                    end
                end
                S_GAP: begin
                    if (idx_q != last_idx) begin
                        idx_n   = idx_q + 6'd1;
                        state_n = S_REQ;
                    end else if (nxt_found) begin
                        idx_n   = 6'd0;
                        roma_n  = nxt_layer;
                        state_n = S_REQ;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign ROM_REQ  = (state_q == S_REQ);
    assign BUSY     = (state_q != S_IDLE);
    // An ack landing on LI belongs to the abandoned line: drop it.
    assign BUF_WE   = ROM_REQ & ROM_ACK & ~LI;
    assign ROMA     = roma_q;
    assign WORD_IDX = idx_q;
    assign BUF_SEL  = sel_q;
    assign OVERRUN  = ovr_q;

endmodule
